// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Multi-cycle multiply/divide sequencer for the HI/LO unit. One 33-bit
// add/subtract path is reused for 32 iterations: shift-and-add for
// multiplies, restoring division for divides. Signed operations run on
// magnitudes and have their signs restored in a single fix-up cycle.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous, active-high; returns to IDLE and clears outputs
//   start  in   1  request, sampled only in IDLE
//   op     in   2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a      in  32  multiplicand / dividend
//   b      in  32  multiplier / divisor
//   busy   out  1  high while iterating or fixing up signs
//   done   out  1  one-cycle pulse; hi/lo/dz valid
//   hi     out 32  product[63:32] or remainder
//   lo     out 32  product[31:0] or quotient
//   dz     out  1  divide-by-zero flag of the last operation
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count, count_next;
  logic [1:0]  op_r, op_next;
  logic        sign_a, sign_a_next;
  logic        sign_b, sign_b_next;
  logic [31:0] mag_b, mag_b_next;
  logic [31:0] hi_next, lo_next;
  logic        dz_next;

  // Magnitudes of the incoming operands; only signed ops take the absolute
  // value. 0x80000000 negates to itself, which is 2^31 read as unsigned.
  logic        in_sign_a, in_sign_b;
  logic [31:0] in_mag_a, in_mag_b;

  // Shared 33-bit add/subtract path.
  logic        sub;
  logic [32:0] add_x, add_y, add_s;
  logic [32:0] prod_s;
  logic [63:0] neg64;

  always_comb begin
    in_sign_a = op[0] & a[31];
    in_sign_b = op[0] & b[31];
    in_mag_a  = in_sign_a ? (32'd0 - a) : a;
    in_mag_b  = in_sign_b ? (32'd0 - b) : b;
  end

  // Divides subtract the divisor from the shifted partial remainder;
  // multiplies add the multiplier to the partial product.
  always_comb begin
    sub    = op_r[1];
    add_x  = sub ? {hi, lo[31]} : {1'b0, hi};
    add_y  = {1'b0, mag_b};
    add_s  = sub ? (add_x - add_y) : (add_x + add_y);
    prod_s = lo[0] ? add_s : {1'b0, hi};
    neg64  = 64'd0 - {hi, lo};
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 5'd0;
      op_r   <= 2'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_b  <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      dz     <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      op_r   <= op_next;
      sign_a <= sign_a_next;
      sign_b <= sign_b_next;
      mag_b  <= mag_b_next;
      hi     <= hi_next;
      lo     <= lo_next;
      dz     <= dz_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next  = state;
    count_next  = count;
    op_next     = op_r;
    sign_a_next = sign_a;
    sign_b_next = sign_b;
    mag_b_next  = mag_b;
    hi_next     = hi;
    lo_next     = lo;
    dz_next     = dz;

    case (state)
      IDLE: begin
        if (start) begin
          op_next     = op;
          sign_a_next = in_sign_a;
          sign_b_next = in_sign_b;
          mag_b_next  = in_mag_b;
          hi_next     = 32'd0;
          lo_next     = in_mag_a;
          dz_next     = 1'b0;
          count_next  = 5'd31;
          state_next  = RUN;
          // Divide by zero skips iteration and reports the raw dividend.
          if (op[1] && (b == 32'd0)) begin
            hi_next    = a;
            lo_next    = 32'hFFFF_FFFF;
            dz_next    = 1'b1;
            state_next = DONE;
          end
        end
      end

      RUN: begin
        if (!op_r[1]) begin
          // Shift the 65-bit {carry,hi,lo} right by one.
          hi_next = prod_s[32:1];
          lo_next = {prod_s[0], lo[31:1]};
        end else if (!add_s[32]) begin
          hi_next = add_s[31:0];
          lo_next = {lo[30:0], 1'b1};
        end else begin
          hi_next = {hi[30:0], lo[31]};
          lo_next = {lo[30:0], 1'b0};
        end
        if (count == 5'd0) state_next = FIX;
        else               count_next = count - 5'd1;
      end

      FIX: begin
        if (!op_r[1]) begin
          if (sign_a ^ sign_b) begin
            hi_next = neg64[63:32];
            lo_next = neg64[31:0];
          end
        end else begin
          // Remainder follows the dividend's sign.
          if (sign_a ^ sign_b) lo_next = 32'd0 - lo;
          if (sign_a)          hi_next = 32'd0 - hi;
        end
        state_next = DONE;
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
// Self-checking bench for muldiv_ctrl: directed cases with known results,
// then random operations checked against a 64-bit arithmetic model.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dz;

  int checks;
  int fails;

  muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dz    (dz)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts a failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Behavioural reference built on plain 64-bit arithmetic.
  task automatic refModel(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output logic [31:0] eh,
                          output logic [31:0] el, output logic edz);
    logic [63:0] p;
    longint      sx, sy, q, r;
    edz = 1'b0;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    case (o)
      2'b00: begin p = 64'(x) * 64'(y); eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = sx * sy;         eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          eh = x; el = 32'hFFFF_FFFF; edz = 1'b1;
        end else if (o == 2'b10) begin
          el = x / y; eh = x % y;
        end else begin
          q = sx / sy; r = sx % sy;
          el = q[31:0]; eh = r[31:0];
        end
      end
    endcase
  endtask

  // Issue one operation and follow it to completion, checking latency,
  // busy width, results and the single-cycle done pulse. Operands and
  // start are scrambled after acceptance to show they are ignored.
  task automatic applyStimulus(input string tag, input logic [1:0] o,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] eh, input logic [31:0] el,
                               input logic edz);
    int cyc;
    int busyCycles;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    checkOutput({tag, ".dz_at_accept"}, 32'(dz), 32'(edz));
    cyc = 0; busyCycles = 0; seen = 0;
    while (!seen && cyc < 100) begin
      if (done) seen = 1;
      else begin
        if (busy) busyCycles++;
        if (cyc == 4) begin start = 1'b1; a = $urandom; b = $urandom; end
        if (cyc == 6) start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    checkOutput({tag, ".done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, ".latency"}, 32'(cyc), edz ? 32'd0 : 32'd33);
    checkOutput({tag, ".busy_cycles"}, 32'(busyCycles), edz ? 32'd0 : 32'd33);
    checkOutput({tag, ".hi"}, hi, eh);
    checkOutput({tag, ".lo"}, lo, el);
    checkOutput({tag, ".dz"}, 32'(dz), 32'(edz));
    // A start presented during DONE must not be accepted.
    start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, ".done_pulse_end"}, 32'(done), 32'd0);
    checkOutput({tag, ".start_in_done_ignored"}, 32'(busy), 32'd0);
    checkOutput({tag, ".hi_hold"}, hi, eh);
    checkOutput({tag, ".lo_hold"}, lo, el);
  endtask

  initial begin
    logic [31:0] eh, el;
    logic        edz;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          cyc;
    bit          sawDone;

    checks = 0; fails = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.hi", hi, 32'd0);
    checkOutput("reset.lo", lo, 32'd0);
    checkOutput("reset.dz", 32'(dz), 32'd0);
    reset = 1'b0;

    $display("[TB] directed cases");
    applyStimulus("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    applyStimulus("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7,
                  32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    applyStimulus("divu_100_7", 2'b10, 32'd100, 32'd7,
                  32'd2, 32'd14, 1'b0);
    applyStimulus("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    applyStimulus("divu_zero", 2'b10, 32'h0000_1234, 32'd0,
                  32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    applyStimulus("multu_clears_dz", 2'b00, 32'd3, 32'd4,
                  32'd0, 32'd12, 1'b0);
    applyStimulus("div_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'd0, 32'h8000_0000, 1'b0);
    applyStimulus("multu_5x6", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

    // Reset in the middle of an operation discards it.
    $display("[TB] mid-operation reset");
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset.busy", 32'(busy), 32'd0);
    checkOutput("midreset.done", 32'(done), 32'd0);
    checkOutput("midreset.hi", hi, 32'd0);
    checkOutput("midreset.lo", lo, 32'd0);
    sawDone = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done || busy) sawDone = 1;
    end
    checkOutput("midreset.no_done", 32'(sawDone), 32'd0);
    applyStimulus("restart_5x6", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 3));
        1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      if (i % 6 == 5) ra = 32'h8000_0000;
      refModel(ro, ra, rb, eh, el, edz);
      applyStimulus($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, eh, el, edz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
